uart_tx_arbiter: RTL



---
 rtl/uart_tx_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter slice.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_REQ      = 2'd2,
    S_WAIT_ACK = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_ACK_TIMEOUT = 65535;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  logic [31:0] idx;

  // Scan ptr+1 .. ptr+NUM_REQ so the previous owner gets lowest priority.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!any_req && req[idx]) begin
        grant   = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART byte transmitter.
// Optional ack watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           eng_tx_data,
  output logic                 eng_tx_data_valid,
  input  logic                 eng_tx_data_ready,
  input  logic                 eng_tx_ack,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("uart_tx_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_timeout
    $error("uart_tx_arbiter: ACK_TIMEOUT must fit the 16-bit watchdog");
  end

  arb_state_t      state, state_nxt;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic            last_q;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            to_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (pick_id),
    .any_req (pick_any)
  );

  assign sel_valid         = req_valid[grant_id];
  assign sel_data          = req_data[{grant_id, 3'b000} +: 8];
  assign eng_tx_data_valid = (state == S_REQ);
  assign busy              = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_any) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (sel_valid) begin
          req_ready[grant_id] = 1'b1;
          state_nxt           = S_REQ;
        end else if (to_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (eng_tx_data_ready) state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (eng_tx_ack)  state_nxt = last_q ? S_IDLE : S_LOAD;
        else if (to_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every return to idle (packet done or watchdog) hands priority past the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant_id    <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      last_q      <= 1'b0;
      eng_tx_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_any) grant_id <= pick_id;
      if (state == S_LOAD && sel_valid) begin
        eng_tx_data <= sel_data;
        last_q      <= req_last[grant_id];
      end
      if (state != S_IDLE && state_nxt == S_IDLE) ptr_q <= grant_id;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        mid_q;
  logic        to_run;

  // S_LOAD only counts between bytes of a packet, never while awaiting the first.
  assign to_run      = (state == S_WAIT_ACK) || (state == S_LOAD && mid_q);
  assign to_hit      = to_run && (to_cnt == 16'(ACK_TIMEOUT));
  assign timeout_err = to_hit && !((state == S_LOAD) && sel_valid)
                              && !((state == S_WAIT_ACK) && eng_tx_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      mid_q  <= 1'b0;
    end else begin
      if (state_nxt != state)            to_cnt <= '0;
      else if (to_run && to_cnt != '1)   to_cnt <= to_cnt + 16'd1;
      if (state == S_IDLE)               mid_q  <= 1'b0;
      else if (state == S_WAIT_ACK && state_nxt == S_LOAD) mid_q <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
